// File: rtl/layer_sched.sv
// Layer scheduler: loads weight beats, streams data beats to the datapath,
// waits out the datapath latency and flags which datapath output samples
// fall inside the valid region of the padded output raster.
module layer_sched #(
  parameter int DW  = 8,
  parameter int CW  = 16,
  parameter int LAT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cfg_layer,
  input  logic [7:0]    cfg_w_len,
  input  logic [CW-1:0] cfg_d_len,
  input  logic [7:0]    cfg_row_len,
  input  logic [7:0]    cfg_valid_cols,
  input  logic [3:0]    cfg_row_step,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [1:0]    dp_layer_num,
  output logic [DW-1:0] dp_data,
  output logic          dp_out_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int LW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t        state_q, state_d;

  // latched configuration
  logic [1:0]    layer_q, layer_d;
  logic [7:0]    w_len_q, w_len_d;
  logic [CW-1:0] d_len_q, d_len_d;
  logic [7:0]    row_len_q, row_len_d;
  logic [7:0]    vcols_q, vcols_d;
  logic [3:0]    row_step_q, row_step_d;

  // sequencing counters
  logic [7:0]    w_cnt_q, w_cnt_d;
  logic [CW-1:0] d_cnt_q, d_cnt_d;
  logic [LW-1:0] dr_cnt_q, dr_cnt_d;

  // output-valid tracking: latency lead-in, sample index, column, row phase
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [CW-1:0] s_cnt_q, s_cnt_d;
  logic [7:0]    col_q, col_d;
  logic [3:0]    rph_q, rph_d;

  logic          err_q, err_d;

  logic accept;
  logic beat;
  logic run_phase;
  logic s_active;

  assign accept    = (state_q == IDLE) && start;
  assign in_ready  = (state_q == LOAD_W) || (state_q == STREAM);
  assign beat      = in_valid && in_ready;
  assign run_phase = (state_q == STREAM) || (state_q == DRAIN);
  // sample index s is non-negative once LAT cycles of STREAM/DRAIN have passed
  assign s_active  = run_phase && (lat_cnt_q == LW'(LAT));

  assign dp_data      = beat ? in_data : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign dp_layer_num = layer_q;
  assign dp_out_valid = s_active && (s_cnt_q < d_len_q) &&
                        (col_q < vcols_q) && (rph_q == 4'd0);

  // next-state selection for the run sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_w_len != 8'd0)       state_d = LOAD_W;
          else if (cfg_d_len != '0)    state_d = STREAM;
          else                         state_d = DRAIN;
        end
      end
      LOAD_W: begin
        if (beat && (w_cnt_q == w_len_q - 8'd1))
          state_d = (d_len_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (d_cnt_q == d_len_q - CW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (dr_cnt_q == LW'(LAT - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of configuration, counters and the underflow flag
  always_comb begin
    layer_d    = layer_q;
    w_len_d    = w_len_q;
    d_len_d    = d_len_q;
    row_len_d  = row_len_q;
    vcols_d    = vcols_q;
    row_step_d = row_step_q;
    w_cnt_d    = w_cnt_q;
    d_cnt_d    = d_cnt_q;
    dr_cnt_d   = dr_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    s_cnt_d    = s_cnt_q;
    col_d      = col_q;
    rph_d      = rph_q;
    err_d      = err_q;
    if (accept) begin
      layer_d    = cfg_layer;
      w_len_d    = cfg_w_len;
      d_len_d    = cfg_d_len;
      row_len_d  = cfg_row_len;
      // more valid columns than the row holds means the whole row is valid
      vcols_d    = (cfg_valid_cols > cfg_row_len) ? cfg_row_len : cfg_valid_cols;
      row_step_d = cfg_row_step;
      w_cnt_d    = '0;
      d_cnt_d    = '0;
      dr_cnt_d   = '0;
      lat_cnt_d  = '0;
      s_cnt_d    = '0;
      col_d      = '0;
      rph_d      = '0;
      err_d      = 1'b0;
    end else begin
      if ((state_q == LOAD_W) && beat && (w_cnt_q != 8'hFF))
        w_cnt_d = w_cnt_q + 8'd1;
      if ((state_q == STREAM) && (d_cnt_q != {CW{1'b1}}))
        d_cnt_d = d_cnt_q + CW'(1);
      if ((state_q == DRAIN) && (dr_cnt_q != LW'(LAT - 1)))
        dr_cnt_d = dr_cnt_q + LW'(1);
      // a missing source beat while streaming is an underflow
      if ((state_q == STREAM) && !in_valid)
        err_d = 1'b1;
      if (run_phase) begin
        if (!s_active) begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end else begin
          if (s_cnt_q != d_len_q) s_cnt_d = s_cnt_q + CW'(1);
          // column wraps at the padded row length; row phase cycles through row_step
          if (col_q == row_len_q - 8'd1) begin
            col_d = '0;
            rph_d = (rph_q == row_step_q - 4'd1) ? 4'd0 : rph_q + 4'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
    end
  end

  // state and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      w_len_q    <= '0;
      d_len_q    <= '0;
      row_len_q  <= '0;
      vcols_q    <= '0;
      row_step_q <= '0;
      w_cnt_q    <= '0;
      d_cnt_q    <= '0;
      dr_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      s_cnt_q    <= '0;
      col_q      <= '0;
      rph_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      w_len_q    <= w_len_d;
      d_len_q    <= d_len_d;
      row_len_q  <= row_len_d;
      vcols_q    <= vcols_d;
      row_step_q <= row_step_d;
      w_cnt_q    <= w_cnt_d;
      d_cnt_q    <= d_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      s_cnt_q    <= s_cnt_d;
      col_q      <= col_d;
      rph_q      <= rph_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DW, default 8: width of the input data byte.
REQ-003 Parameter CW, default 16: width of the length and cycle counters.
REQ-004 Parameter LAT, default 7: cycles from the first data sample driven on dp_data to the first datapath output.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 start  in  1  one-cycle request to run one layer with the cfg_* values.
REQ-008 cfg_layer  in  2  layer index forwarded to the datapath.
REQ-009 cfg_w_len  in  8  number of weight beats.
REQ-010 cfg_d_len  in  CW  number of data cycles.
REQ-011 cfg_row_len  in  8  padded row length of the output raster, in samples; must be 1 or more.
REQ-012 cfg_valid_cols  in  8  leading columns of each row that are valid.
REQ-013 cfg_row_step  in  4  valid-row decimation factor; must be 1 or more.
REQ-014 in_valid  in  1  source beat valid.
REQ-015 in_data  in  DW  source beat.
REQ-016 in_ready  out  1  block accepts the beat.
REQ-017 dp_layer_num  out  2  layer select to the datapath.
REQ-018 dp_data  out  DW  byte stream to the datapath input buffer.
REQ-019 dp_out_valid  out  1  datapath output sample is valid this cycle.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 err  out  1  sticky underflow flag.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-024 In IDLE, start=1 SHALL latch all cfg_* inputs, clear err, and transition as follows:
- to LOAD_W if cfg_w_len≠0;
- else to STREAM if cfg_d_len≠0;
- else to DRAIN.
REQ-025 start SHALL be ignored in every state except IDLE; the latched configuration SHALL NOT change mid-run.
REQ-026 in_ready SHALL be 1 in LOAD_W and STREAM, and 0 in all other states.
REQ-027 A beat is defined as in_valid & in_ready; on a beat, dp_data SHALL equal in_data combinationally, otherwise dp_data SHALL be 0.
REQ-028 LOAD_W behaviour:
- gaps are allowed, and the weight counter holds during a gap;
- on the beat that reaches cfg_w_len, the next state SHALL be STREAM, or DRAIN if cfg_d_len=0.
REQ-029 STREAM SHALL last exactly cfg_d_len cycles, with the counter advancing every cycle.
REQ-030 A STREAM cycle with in_valid=0 SHALL drive dp_data=0 and set err; err stays set until the next accepted start.
REQ-031 After the last STREAM cycle the FSM SHALL enter DRAIN.
REQ-032 DRAIN SHALL last exactly LAT cycles, then go to DONE.
REQ-033 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-034 Output-valid index: let t=0 be the first STREAM cycle and s=t-LAT.
REQ-035 dp_out_valid SHALL be 1 iff all of the following hold:
- 0 ≤ s < cfg_d_len;
- (s mod cfg_row_len) < cfg_valid_cols;
- (s div cfg_row_len) mod cfg_row_step = 0.
REQ-036 The output-valid logic SHALL be implemented with column, row and row-phase counters, with no divider.
REQ-037 The output-valid window SHALL overlap STREAM and DRAIN and SHALL NOT extend past the final DRAIN cycle; s values at or beyond cfg_d_len are never valid.
REQ-038 dp_layer_num SHALL hold the latched cfg_layer from the start cycle onward and keep it after done until the next accepted start.
REQ-039 Counters SHALL saturate at their terminal count, with no wrap-around within a run.
REQ-040 cfg_valid_cols > cfg_row_len SHALL behave as cfg_valid_cols = cfg_row_len.

Reset
REQ-041 While rst=1, all of the following SHALL hold:
- state=IDLE, with all counters 0;
- in_ready=0, dp_data=0, dp_out_valid=0;
- busy=0, done=0, err=0, dp_layer_num=0.
REQ-042 Reset asserted mid-run SHALL abort the run immediately, with no done pulse.
REQ-043 After reset deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-044 Scenario: w_len=9, d_len=20, row_len=5, valid_cols=3, row_step=2, LAT=7, with a continuous source. Required response:
- 9 weight beats are taken;
- dp_out_valid is high at s=0,1,2,10,11,12;
- done occurs 9+20+7+1 cycles after start;
- err=0.
REQ-045 Scenario: in_valid low for 2 cycles in LOAD_W. Required response: the weight count holds, STREAM entry is delayed by 2 cycles, and err=0.
REQ-046 Scenario: in_valid low on STREAM cycle 4. Required response: dp_data=0 that cycle, err=1 until the next start, and done timing is unchanged.
REQ-047 Scenario: w_len=0 and d_len=0. Required response: IDLE→DRAIN→DONE, done occurs LAT+1 cycles after start, and dp_out_valid is never asserted.
REQ-048 Scenario: start pulsed during STREAM. Required response: the start is ignored and the configuration and timing are unchanged.
REQ-049 Scenario: rst asserted in DRAIN. Required response: all outputs return to their reset values in the same cycle, and a new start is accepted afterward.
